// File: rtl/bf16_add_norm.sv
// rtl/bf16_add_norm.sv - two-stage normalize/round back end for a bf16 adder
module bf16_add_norm #(
  parameter int E = 8,
  parameter int M = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic         s_i,
  input  logic [E-1:0] e_i,
  input  logic [M+4:0] n_i,
  input  logic         nan_i,
  input  logic         inf_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         s_o,
  output logic [E-1:0] e_o,
  output logic [M-1:0] m_o,
  output logic         ovf_o,
  output logic         unf_o
);

  localparam int W  = M + 5;
  localparam int LW = $clog2(W + 1);
  localparam logic signed [E+1:0] EMAX  = (E+2)'((1 << E) - 1);
  localparam logic signed [E+1:0] EZERO = '0;
  localparam logic [M-1:0] QNAN_M = {1'b1, {(M-1){1'b0}}};

  // stage 1 holding registers
  logic          v1;
  logic          s1, nan1, inf1;
  logic [E-1:0]  e1;
  logic [W-1:0]  n1;
  logic [LW-1:0] lz1;

  logic          accept, adv;
  logic [LW-1:0] lz;

  assign ready_o = ~v1 | ~valid_o | ready_i;
  assign accept  = valid_i & ready_o;
  assign adv     = v1 & (~valid_o | ready_i);

  // leading-zero count from the carry bit down; W when the sum is zero
  always_comb begin
    lz = LW'(W);
    for (int i = 0; i < W; i++) begin
      if (n_i[i]) lz = LW'(W - 1 - i);
    end
  end

  // stage 1 register: capture the beat and its leading-zero count
  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      s1   <= 1'b0;
      e1   <= '0;
      n1   <= '0;
      nan1 <= 1'b0;
      inf1 <= 1'b0;
      lz1  <= '0;
    end else if (accept) begin
      v1   <= 1'b1;
      s1   <= s_i;
      e1   <= e_i;
      n1   <= n_i;
      nan1 <= nan_i;
      inf1 <= inf_i;
      lz1  <= lz;
    end else if (adv) begin
      v1   <= 1'b0;
    end
  end

  logic [LW-1:0]         k;
  logic [W-1:0]          sh;
  logic [M-1:0]          m_pre, m_fin;
  logic                  g, st, inc;
  logic [M:0]            m_sum;
  logic signed [E+1:0]   e_norm, e_fin;
  logic                  nxt_s, nxt_ovf, nxt_unf;
  logic [E-1:0]          nxt_e;
  logic [M-1:0]          nxt_m;

  // shift to put the hidden bit in place, round to nearest even, classify
  always_comb begin
    k = lz1 - LW'(1);
    if (n1[W-1]) begin
      // carry: one right shift, the dropped bit folds into sticky
      sh     = {1'b0, n1[W-1:2], n1[1] | n1[0]};
      e_norm = $signed({2'b00, e1}) + (E+2)'(1);
    end else begin
      sh     = n1 << k;
      e_norm = $signed({2'b00, e1}) - $signed({{(E+2-LW){1'b0}}, k});
    end
    m_pre = sh[M+2:3];
    g     = sh[2];
    st    = |sh[1:0];
    inc   = g & (st | m_pre[0]);
    m_sum = {1'b0, m_pre} + (M+1)'(inc);
    e_fin = e_norm;
    m_fin = m_sum[M-1:0];
    if (m_sum[M]) begin
      m_fin = '0;
      e_fin = e_norm + (E+2)'(1);
    end

    nxt_s   = s1;
    nxt_e   = e_fin[E-1:0];
    nxt_m   = m_fin;
    nxt_ovf = 1'b0;
    nxt_unf = 1'b0;
    if (nan1) begin
      nxt_s = 1'b0;
      nxt_e = '1;
      nxt_m = QNAN_M;
    end else if (inf1) begin
      nxt_e = '1;
      nxt_m = '0;
    end else if (n1 == '0) begin
      nxt_s = 1'b0;
      nxt_e = '0;
      nxt_m = '0;
    end else if (e_norm <= EZERO) begin
      // no subnormals: anything shifted to or below exponent zero flushes
      nxt_e   = '0;
      nxt_m   = '0;
      nxt_unf = 1'b1;
    end else if (e_fin >= EMAX) begin
      nxt_e   = '1;
      nxt_m   = '0;
      nxt_ovf = 1'b1;
    end
  end

  // stage 2 register: result holds while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o <= 1'b0;
      s_o     <= 1'b0;
      e_o     <= '0;
      m_o     <= '0;
      ovf_o   <= 1'b0;
      unf_o   <= 1'b0;
    end else if (adv) begin
      valid_o <= 1'b1;
      s_o     <= nxt_s;
      e_o     <= nxt_e;
      m_o     <= nxt_m;
      ovf_o   <= nxt_ovf;
      unf_o   <= nxt_unf;
    end else if (valid_o & ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bf16_add_norm.sv
// tb/tb_bf16_add_norm.sv - self-checking bench for bf16_add_norm
module tb_bf16_add_norm;

  logic        clk = 1'b0;
  logic        rst, valid_i, ready_i, s_i, nan_i, inf_i;
  logic [7:0]  e_i;
  logic [11:0] n_i;
  logic        ready_o, valid_o, s_o, ovf_o, unf_o;
  logic [7:0]  e_o;
  logic [6:0]  m_o;

  logic [17:0] exp_q[$];
  int          nchk = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  bf16_add_norm #(.E(8), .M(7)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .s_i(s_i), .e_i(e_i), .n_i(n_i), .nan_i(nan_i), .inf_i(inf_i),
    .valid_o(valid_o), .ready_i(ready_i), .s_o(s_o), .e_o(e_o),
    .m_o(m_o), .ovf_o(ovf_o), .unf_o(unf_o)
  );

  // value-level reference: locate the MSB, keep 8 significant bits, RNE the rest
  function automatic logic [17:0] model(input logic s, input logic [7:0] e,
                                        input logic [11:0] n, input logic nan,
                                        input logic inf);
    int p, sh, sig, rem, half, ex;
    if (nan) return {1'b0, 8'hFF, 7'h40, 2'b00};
    if (inf) return {s, 8'hFF, 7'h00, 2'b00};
    if (n == 12'd0) return 18'd0;
    p = 0;
    for (int i = 0; i < 12; i++) if (n[i]) p = i;
    ex = int'(e) + p - 10;
    if (ex <= 0) return {s, 8'h00, 7'h00, 2'b01};
    sh = p - 7;
    if (sh > 0) begin
      sig  = int'(n) >> sh;
      rem  = int'(n) & ((1 << sh) - 1);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && (sig % 2) == 1)) sig++;
    end else begin
      sig = int'(n) << (-sh);
    end
    if (sig == 256) begin
      sig = 128;
      ex++;
    end
    if (ex >= 255) return {s, 8'hFF, 7'h00, 2'b10};
    return {s, ex[7:0], sig[6:0], 2'b00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    nchk++;
    assert (obs === exp_v) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, obs, exp_v);
    end
  endtask

  // sample handshakes mid-cycle, score outputs, then advance one clock
  task automatic tick();
    #1;
    if (!rst && valid_o && ready_i) begin
      if (exp_q.size() == 0) chk("unexpected_beat", 32'(exp_q.size()), 32'd1);
      else begin
        chk("beat", {14'd0, s_o, e_o, m_o, ovf_o, unf_o}, {14'd0, exp_q.pop_front()});
        chk("flags_excl", {31'd0, ovf_o & unf_o}, 32'd0);
      end
    end
    if (!rst && valid_i && ready_o) exp_q.push_back(model(s_i, e_i, n_i, nan_i, inf_i));
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beat();
    s_i   = 1'($urandom_range(0, 1));
    e_i   = 8'($urandom_range(0, 255));
    n_i   = 12'($urandom_range(0, 4095) >> $urandom_range(0, 11));
    nan_i = ($urandom_range(0, 15) == 0);
    inf_i = ($urandom_range(0, 15) == 0);
  endtask

  task automatic directed(input string tag, input logic s, input logic [7:0] e,
                          input logic [11:0] n, input logic [15:0] word,
                          input logic ov, input logic un);
    ready_i = 1'b1;
    valid_i = 1'b1;
    s_i = s; e_i = e; n_i = n; nan_i = 1'b0; inf_i = 1'b0;
    tick();
    valid_i = 1'b0;
    tick();
    chk({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
    chk(tag, {14'd0, s_o, e_o, m_o, ovf_o, unf_o}, {14'd0, word, ov, un});
    tick();
  endtask

  logic [17:0] hold;

  initial begin
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    s_i = 1'b0; e_i = '0; n_i = '0; nan_i = 1'b0; inf_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_valid_o", {31'd0, valid_o}, 32'd0);
    chk("rst_ready_o", {31'd0, ready_o}, 32'd1);
    chk("rst_outputs", {14'd0, s_o, e_o, m_o, ovf_o, unf_o}, 32'd0);

    directed("carry",      1'b0, 8'd127, 12'h800, 16'h4000, 1'b0, 1'b0);
    directed("cancel",     1'b0, 8'd127, 12'h008, 16'h3C00, 1'b0, 1'b0);
    directed("zero",       1'b1, 8'd127, 12'h000, 16'h0000, 1'b0, 1'b0);
    directed("rne_up",     1'b0, 8'd127, 12'b0100_0000_1100, 16'h3F82, 1'b0, 1'b0);
    directed("rne_even",   1'b0, 8'd127, 12'b0100_0000_0100, 16'h3F80, 1'b0, 1'b0);
    directed("overflow",   1'b0, 8'd254, 12'h800, 16'h7F80, 1'b1, 1'b0);
    directed("underflow",  1'b0, 8'd3,   12'h008, 16'h0000, 1'b0, 1'b1);
    directed("round_ovf",  1'b1, 8'd254, 12'h7FC, 16'hFF80, 1'b1, 1'b0);

    // backpressure: three beats offered against a stalled consumer
    ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      valid_i = 1'b1;
      rand_beat();
      tick();
    end
    rand_beat();
    #1;
    chk("bp_ready_o", {31'd0, ready_o}, 32'd0);
    chk("bp_accepted", 32'(exp_q.size()), 32'd2);
    tick();
    valid_i = 1'b0;
    hold = {s_o, e_o, m_o, ovf_o, unf_o};
    repeat (3) tick();
    chk("bp_valid_held", {31'd0, valid_o}, 32'd1);
    chk("bp_stable", {14'd0, s_o, e_o, m_o, ovf_o, unf_o}, {14'd0, hold});
    ready_i = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    tick();
    chk("bp_idle", {31'd0, valid_o}, 32'd0);

    // reset with both stages occupied
    ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      valid_i = 1'b1;
      rand_beat();
      tick();
    end
    chk("full_before_rst", {31'd0, valid_o}, 32'd1);
    rst = 1'b1;
    rand_beat();
    tick();
    exp_q.delete();
    rst = 1'b0;
    valid_i = 1'b0;
    #1;
    chk("mid_rst_valid_o", {31'd0, valid_o}, 32'd0);
    chk("mid_rst_ready_o", {31'd0, ready_o}, 32'd1);
    chk("mid_rst_outputs", {14'd0, s_o, e_o, m_o, ovf_o, unf_o}, 32'd0);
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_stale_beat", {31'd0, valid_o}, 32'd0);
    end

    // randomized traffic with random stalls
    for (int i = 0; i < 600; i++) begin
      valid_i = 1'($urandom_range(0, 1));
      ready_i = ($urandom_range(0, 3) != 0);
      rand_beat();
      tick();
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
    chk("final_drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/bf16_add_norm.md
BF16_ADD_NORM -- requirements
Module: bf16_add_norm

Interface
REQ-001 SHALL have parameters: E, 8, exponent width; M, 7, stored mantissa width.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: valid_i  in  1  input beat valid; ready_o  out  1  block accepts input.
REQ-004 SHALL have ports: s_i  in  1  result sign; e_i  in  E  larger operand exponent (biased).
REQ-005 SHALL have port: n_i  in  M+5  raw sum, layout {carry, hidden, m[M-1:0], guard, round, sticky}; value = n_i/2^(M+3) * 2^(e_i-127).
REQ-006 SHALL have ports: nan_i  in  1  result is NaN; inf_i  in  1  result is infinity (from upstream classify).
REQ-007 SHALL have ports: valid_o  out  1; ready_i  in  1; s_o  out  1; e_o  out  E; m_o  out  M; ovf_o  out  1  overflowed to inf; unf_o  out  1  flushed to zero.
REQ-008 SHALL use one clock domain; reset synchronous, active-high, sampled on clk rising edge.

Function
REQ-009 SHALL be a 2-stage pipeline: S1 registers leading-zero count (lz, counted from bit M+4) and operands; S2 registers shifted, rounded result.
REQ-010 SHALL have latency 2 cycles from accepted beat to valid_o with ready_i held high; throughput 1 beat/cycle.
REQ-011 SHALL accept a beat when valid_i & ready_o; ready_o = ~v1 | ~valid_o | ready_i (v1 = S1 occupancy).
REQ-012 SHALL advance S1->S2 when v1 & (~valid_o | ready_i); S2 clears when valid_o & ready_i and no new beat enters.
REQ-013 SHALL hold s_o, e_o, m_o, ovf_o, unf_o stable while valid_o & ~ready_i; no beat dropped or duplicated.
REQ-014 SHALL normalize: k = lz-1; carry set -> right shift 1, e = e_i+1, shifted-out bit ORed into sticky; else left shift k, e = e_i-k.
REQ-015 SHALL compute after shift: m = bits[M+2:3], g = bit[2], st = |bits[1:0].
REQ-016 SHALL round to nearest even: increment m when g & (st | m[0]); mantissa carry-out -> m = 0, e = e+1.
REQ-017 SHALL output e_o=FF, m_o=0, s_o=s_i, ovf_o=1 when final e >= 255.
REQ-018 SHALL output e_o=0, m_o=0, s_o=s_i, unf_o=1 (no subnormals) when final e <= 0, including k >= e_i.
REQ-019 SHALL output +0 (s_o=0, e_o=0, m_o=0, unf_o=0) when n_i == 0 (exact cancellation).
REQ-020 SHALL output e_o=FF, m_o=7'h40, s_o=0 when nan_i; else e_o=FF, m_o=0, s_o=s_i when inf_i; nan_i takes precedence; flags 0 in both cases.
REQ-021 SHALL update ovf_o/unf_o together with data; both never 1 at once.

Reset
REQ-022 SHALL on rst clear v1 and valid_o, drive s_o, e_o, m_o, ovf_o, unf_o to 0, ready_o=1 in the cycle after reset; beats in flight are discarded.
REQ-023 SHALL ignore valid_i during a cycle with rst high.

Verification
REQ-024 SHALL cover carry: s=0, e_i=127, n_i=12'h800 -> after 2 cycles {s,e,m}=0x4000, flags 0.
REQ-025 SHALL cover cancellation: e_i=127, n_i=12'h008 -> 0x3C00; n_i=12'h000 -> 0x0000, unf_o=0.
REQ-026 SHALL cover RNE ties: e_i=127, n_i=12'b0100_0000_1100 -> 0x3F82; n_i=12'b0100_0000_0100 -> 0x3F80.
REQ-027 SHALL cover overflow/underflow: e_i=254, n_i=12'h800 -> 0x7F80, ovf_o=1; e_i=3, n_i=12'h008 -> 0x0000, unf_o=1.
REQ-028 SHALL cover backpressure: ready_i=0, 3 beats offered back-to-back -> 2 accepted, ready_o=0 on third, output stable; ready_i=1 -> beats emerge in order, none lost.
REQ-029 SHALL cover reset mid-operation: rst with both stages full -> next cycle valid_o=0, outputs 0, ready_o=1; no stale beat emerges.
